// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: front-end for traffic_light_controller.
// Synchronises and debounces the road-loop sensor, counts qualified arrivals
// until green serves them, and qualifies the emergency-vehicle input with a
// stuck-sensor lockout so a jammed request cannot hold the junction forever.
module car_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EMERG_QUAL      = 2,
    parameter int EMERG_MAX       = 20,
    parameter int CNT_W           = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sensor_raw,
    input  logic             emerg_raw,
    input  logic             green,
    output logic             car,
    output logic [CNT_W-1:0] car_count,
    output logic             emergency,
    output logic             emerg_fault
);

    localparam int DC_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int ET_SPAN = (EMERG_MAX > EMERG_QUAL) ? EMERG_MAX : EMERG_QUAL;
    localparam int ET_W    = $clog2(ET_SPAN) + 1;

    localparam logic [DC_W-1:0]  DEB_LAST  = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ET_W-1:0]  QUAL_LAST = ET_W'(EMERG_QUAL - 1);
    localparam logic [ET_W-1:0]  MAX_LAST  = ET_W'(EMERG_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        ARRIVING = 2'd1,
        PRESENT  = 2'd2,
        LEAVING  = 2'd3
    } car_state_t;

    typedef enum logic [1:0] {
        E_IDLE    = 2'd0,
        E_QUAL    = 2'd1,
        E_ACTIVE  = 2'd2,
        E_LOCKOUT = 2'd3
    } emerg_state_t;

    logic sens_meta_q,  sens_meta_d;
    logic sens_sync_q,  sens_sync_d;
    logic emerg_meta_q, emerg_meta_d;
    logic emerg_sync_q, emerg_sync_d;

    car_state_t       car_state_q, car_state_d;
    logic [DC_W-1:0]  car_cnt_q,   car_cnt_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             arrival;

    emerg_state_t     emerg_state_q, emerg_state_d;
    logic [ET_W-1:0]  etmr_q,        etmr_d;
    logic             emergency_q,   emergency_d;
    logic             emerg_fault_q, emerg_fault_d;

    // Two-flop synchronisers: raw levels are only ever looked at through these.
    always_comb begin
        sens_meta_d  = sensor_raw;
        sens_sync_d  = sens_meta_q;
        emerg_meta_d = emerg_raw;
        emerg_sync_d = emerg_meta_q;
    end

    // Car debounce FSM; arrival is combinational so the count moves on the qualifying edge.
    always_comb begin
        car_state_d = car_state_q;
        car_cnt_d   = car_cnt_q;
        arrival     = 1'b0;
        unique case (car_state_q)
            ABSENT: begin
                if (sens_sync_q) begin
                    car_state_d = ARRIVING;
                    car_cnt_d   = DC_W'(1);
                end
            end
            ARRIVING: begin
                if (!sens_sync_q) begin
                    car_state_d = ABSENT;
                    car_cnt_d   = '0;
                end else if (car_cnt_q == DEB_LAST) begin
                    car_state_d = PRESENT;
                    car_cnt_d   = '0;
                    arrival     = 1'b1;
                end else begin
                    car_cnt_d = car_cnt_q + DC_W'(1);
                end
            end
            PRESENT: begin
                if (!sens_sync_q) begin
                    car_state_d = LEAVING;
                    car_cnt_d   = DC_W'(1);
                end
            end
            LEAVING: begin
                if (sens_sync_q) begin
                    car_state_d = PRESENT;
                    car_cnt_d   = '0;
                end else if (car_cnt_q == DEB_LAST) begin
                    car_state_d = ABSENT;
                    car_cnt_d   = '0;
                end else begin
                    car_cnt_d = car_cnt_q + DC_W'(1);
                end
            end
            default: begin
                car_state_d = ABSENT;
                car_cnt_d   = '0;
            end
        endcase
    end

    // Waiting-car counter: green serves everyone (including a car qualifying that edge), otherwise saturate.
    always_comb begin
        count_d = count_q;
        if (green) begin
            count_d = '0;
        end else if (arrival && (count_q != CNT_SAT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Emergency qualify / active-timeout / lockout FSM with outputs decoded from the next state.
    always_comb begin
        emerg_state_d = emerg_state_q;
        etmr_d        = etmr_q;
        unique case (emerg_state_q)
            E_IDLE: begin
                if (emerg_sync_q) begin
                    if (EMERG_QUAL == 1) begin
                        emerg_state_d = E_ACTIVE;
                        etmr_d        = '0;
                    end else begin
                        emerg_state_d = E_QUAL;
                        etmr_d        = ET_W'(1);
                    end
                end
            end
            E_QUAL: begin
                if (!emerg_sync_q) begin
                    emerg_state_d = E_IDLE;
                    etmr_d        = '0;
                end else if (etmr_q == QUAL_LAST) begin
                    emerg_state_d = E_ACTIVE;
                    etmr_d        = '0;
                end else begin
                    etmr_d = etmr_q + ET_W'(1);
                end
            end
            E_ACTIVE: begin
                if (!emerg_sync_q) begin
                    emerg_state_d = E_IDLE;
                    etmr_d        = '0;
                end else if (etmr_q == MAX_LAST) begin
                    emerg_state_d = E_LOCKOUT;
                    etmr_d        = '0;
                end else begin
                    etmr_d = etmr_q + ET_W'(1);
                end
            end
            E_LOCKOUT: begin
                if (!emerg_sync_q) begin
                    emerg_state_d = E_IDLE;
                    etmr_d        = '0;
                end
            end
            default: begin
                emerg_state_d = E_IDLE;
                etmr_d        = '0;
            end
        endcase
        emergency_d   = (emerg_state_d == E_ACTIVE);
        emerg_fault_d = (emerg_state_d == E_LOCKOUT);
    end

    // All state registers; reset clears everything so partial qualification is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sens_meta_q   <= 1'b0;
            sens_sync_q   <= 1'b0;
            emerg_meta_q  <= 1'b0;
            emerg_sync_q  <= 1'b0;
            car_state_q   <= ABSENT;
            car_cnt_q     <= '0;
            count_q       <= '0;
            emerg_state_q <= E_IDLE;
            etmr_q        <= '0;
            emergency_q   <= 1'b0;
            emerg_fault_q <= 1'b0;
        end else begin
            sens_meta_q   <= sens_meta_d;
            sens_sync_q   <= sens_sync_d;
            emerg_meta_q  <= emerg_meta_d;
            emerg_sync_q  <= emerg_sync_d;
            car_state_q   <= car_state_d;
            car_cnt_q     <= car_cnt_d;
            count_q       <= count_d;
            emerg_state_q <= emerg_state_d;
            etmr_q        <= etmr_d;
            emergency_q   <= emergency_d;
            emerg_fault_q <= emerg_fault_d;
        end
    end

    assign car_count   = count_q;
    assign car         = (count_q != '0);
    assign emergency   = emergency_q;
    assign emerg_fault = emerg_fault_q;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Testbench for car_sensor_conditioner: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model built from sample windows and run lengths.
module tb_car_sensor_conditioner;

    localparam int D   = 4;
    localparam int Q   = 2;
    localparam int MX  = 20;
    localparam int W   = 4;
    localparam int SAT = (1 << W) - 1;

    logic         clock;
    logic         reset;
    logic         sensor_raw;
    logic         emerg_raw;
    logic         green;
    logic         car;
    logic [W-1:0] car_count;
    logic         emergency;
    logic         emerg_fault;

    int compared;
    int mismatched;

    car_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .EMERG_QUAL     (Q),
        .EMERG_MAX      (MX),
        .CNT_W          (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sensor_raw (sensor_raw),
        .emerg_raw  (emerg_raw),
        .green      (green),
        .car        (car),
        .car_count  (car_count),
        .emergency  (emergency),
        .emerg_fault(emerg_fault)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model state: raw sample history, debounced presence, run length of emergency.
    bit sensHist[$];
    bit emergHist[$];
    bit seenWin[$];
    bit present;
    bit seenS;
    bit seenE;
    bit allOnes;
    bit allZeros;
    bit arrived;
    int expCount;
    int eRun;

    // Model: each FSM sees the raw level from two edges earlier; a car is confirmed
    // after D consecutive seen highs, departs after D consecutive seen lows;
    // emergency is active while the high run length lies in [Q, Q+MX).
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            sensHist.delete();
            emergHist.delete();
            seenWin.delete();
            present  = 1'b0;
            expCount = 0;
            eRun     = 0;
        end else begin
            sensHist.push_front(sensor_raw);
            emergHist.push_front(emerg_raw);
            if (sensHist.size() > 3) void'(sensHist.pop_back());
            if (emergHist.size() > 3) void'(emergHist.pop_back());
            seenS = (sensHist.size() == 3) ? sensHist[2] : 1'b0;
            seenE = (emergHist.size() == 3) ? emergHist[2] : 1'b0;
            seenWin.push_front(seenS);
            if (seenWin.size() > D) void'(seenWin.pop_back());
            allOnes  = (seenWin.size() == D);
            allZeros = 1'b1;
            foreach (seenWin[i]) begin
                if (!seenWin[i]) allOnes = 1'b0;
                if (seenWin[i]) allZeros = 1'b0;
            end
            arrived = !present && allOnes;
            if (arrived) present = 1'b1;
            else if (present && allZeros) present = 1'b0;
            if (green) expCount = 0;
            else if (arrived && expCount < SAT) expCount = expCount + 1;
            eRun = seenE ? ((eRun < 1000) ? eRun + 1 : eRun) : 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clock) begin
        checkOutput("model car",         int'(car),         int'(expCount != 0));
        checkOutput("model car_count",   int'(car_count),   expCount);
        checkOutput("model emergency",   int'(emergency),   int'(eRun >= Q && eRun < Q + MX));
        checkOutput("model emerg_fault", int'(emerg_fault), int'(eRun >= Q + MX));
    end

    task automatic applyStimulus(input logic sens, input logic emerg, input logic grn);
        sensor_raw = sens;
        emerg_raw  = emerg;
        green      = grn;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic runCar(input int high, input int low);
        sensor_raw = 1'b1;
        waitEdges(high);
        sensor_raw = 1'b0;
        waitEdges(low);
    endtask

    task automatic clearWithGreen();
        green = 1'b1;
        waitEdges(1);
        green = 1'b0;
    endtask

    int sensHold;
    int emergHold;

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitEdges(3);
        checkOutput("reset car",         int'(car),         0);
        checkOutput("reset car_count",   int'(car_count),   0);
        checkOutput("reset emergency",   int'(emergency),   0);
        checkOutput("reset emerg_fault", int'(emerg_fault), 0);
        reset = 1'b0;
        waitEdges(1);
        checkOutput("post-release car", int'(car), 0);
        waitEdges(3);

        // Clean arrival: rises at edge 5, no decrement on departure.
        $display("[TB] clean arrival");
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitEdges(5);
        checkOutput("arrival edge4 car", int'(car), 0);
        waitEdges(1);
        checkOutput("arrival edge5 car",   int'(car),       1);
        checkOutput("arrival edge5 count", int'(car_count), 1);
        waitEdges(6);
        sensor_raw = 1'b0;
        waitEdges(10);
        checkOutput("after departure count", int'(car_count), 1);
        clearWithGreen();
        checkOutput("green clears count", int'(car_count), 0);
        checkOutput("green clears car",   int'(car),       0);

        // Glitch rejection and bounce during PRESENT.
        $display("[TB] glitch rejection");
        runCar(3, 8);
        checkOutput("3-cycle glitch count", int'(car_count), 0);
        sensor_raw = 1'b1;
        waitEdges(8);
        sensor_raw = 1'b0;
        waitEdges(1);
        sensor_raw = 1'b1;
        waitEdges(6);
        checkOutput("bounce count", int'(car_count), 1);
        sensor_raw = 1'b0;
        waitEdges(10);
        clearWithGreen();

        // Queue of three, serve, arrival on a green edge, saturation.
        $display("[TB] queue and serve");
        for (int c = 0; c < 3; c++) runCar(8, 8);
        checkOutput("three cars count", int'(car_count), 3);
        clearWithGreen();
        checkOutput("served count", int'(car_count), 0);
        checkOutput("served car",   int'(car),       0);
        sensor_raw = 1'b1;
        waitEdges(5);
        green = 1'b1;
        waitEdges(1);
        green = 1'b0;
        checkOutput("arrival on green count", int'(car_count), 0);
        waitEdges(3);
        checkOutput("arrival on green later", int'(car_count), 0);
        sensor_raw = 1'b0;
        waitEdges(10);
        for (int c = 0; c < 20; c++) runCar(8, 8);
        checkOutput("saturated count", int'(car_count), SAT);
        clearWithGreen();

        // Emergency for 8 cycles: high on edges 3..9.
        $display("[TB] emergency pulse");
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitEdges(3);
        checkOutput("emerg edge2", int'(emergency), 0);
        waitEdges(1);
        checkOutput("emerg edge3", int'(emergency), 1);
        waitEdges(4);
        emerg_raw = 1'b0;
        waitEdges(2);
        checkOutput("emerg edge9", int'(emergency), 1);
        waitEdges(1);
        checkOutput("emerg edge10",       int'(emergency),   0);
        checkOutput("emerg edge10 fault", int'(emerg_fault), 0);
        waitEdges(6);

        // Stuck emergency for 40 cycles: active 3..22, lockout 23..41.
        $display("[TB] stuck emergency");
        emerg_raw = 1'b1;
        waitEdges(23);
        checkOutput("stuck edge22 emerg", int'(emergency),   1);
        checkOutput("stuck edge22 fault", int'(emerg_fault), 0);
        waitEdges(1);
        checkOutput("stuck edge23 emerg", int'(emergency),   0);
        checkOutput("stuck edge23 fault", int'(emerg_fault), 1);
        waitEdges(16);
        emerg_raw = 1'b0;
        waitEdges(2);
        checkOutput("stuck edge41 fault", int'(emerg_fault), 1);
        waitEdges(1);
        checkOutput("stuck edge42 fault", int'(emerg_fault), 0);
        waitEdges(6);

        // Reset mid-operation with a car waiting, one arriving and emergency active.
        $display("[TB] reset mid-operation");
        runCar(8, 8);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitEdges(4);
        checkOutput("pre-reset emergency", int'(emergency), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset car",       int'(car),       0);
        checkOutput("async reset count",     int'(car_count), 0);
        checkOutput("async reset emergency", int'(emergency), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        emerg_raw = 1'b0;
        waitEdges(5);
        checkOutput("post-reset edge4 car", int'(car), 0);
        waitEdges(1);
        checkOutput("post-reset edge5 car", int'(car), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitEdges(10);
        clearWithGreen();

        // Randomized traffic with occasional asynchronous resets.
        $display("[TB] random traffic");
        sensHold  = 0;
        emergHold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (sensHold == 0) begin
                sensor_raw = 1'($urandom_range(0, 1));
                sensHold   = $urandom_range(1, 12);
            end else begin
                sensHold--;
            end
            if (emergHold == 0) begin
                emerg_raw = 1'($urandom_range(0, 1));
                emergHold = $urandom_range(1, 30);
            end else begin
                emergHold--;
            end
            green = ($urandom_range(0, 15) == 0);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset = 1'b1;
            waitEdges(1);
        end
        reset = 1'b0;
        waitEdges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/car_sensor_conditioner.md
Name: car_sensor_conditioner

Overview:
Upstream front-end for traffic_light_controller. It conditions the raw road-loop sensor and the raw emergency-vehicle input: 2-flop synchronisation, debounce, and arrival counting. It drives the controller's `car` input and a qualified `emergency` request, and takes the controller's `green` as feedback to retire waiting cars.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples needed to confirm car arrival or departure (legal range >=2)
EMERG_QUAL, 2, consecutive synchronised high samples needed to assert emergency (legal range >=1)
EMERG_MAX, 20, maximum cycles emergency may stay asserted before stuck-sensor lockout (legal range >=1)
CNT_W, 4, width of the waiting-car counter

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
sensor_raw  in  1  asynchronous raw loop-sensor level (1 = metal present)
emerg_raw  in  1  asynchronous raw emergency-vehicle request level
green  in  1  green lamp from traffic_light_controller; synchronous to clock
car  out  1  high while car_count != 0; connects to the controller's car input
car_count  out  CNT_W  number of qualified arrivals not yet served
emergency  out  1  qualified emergency request
emerg_fault  out  1  high while in stuck-emergency lockout

Behaviour:
- Reset: all flops are cleared asynchronously.
  - Car FSM goes to ABSENT; emergency FSM goes to E_IDLE.
  - car, car_count, emergency and emerg_fault are all 0 while reset is high and on the first edge after release.
- Synchronisers: two flops per raw input, giving s_sens and s_emerg.
  - An input first sampled high at edge k is seen by the FSMs at edge k+2.
- Car FSM, with cnt counting consecutive samples (width clog2(DEBOUNCE_CYCLES)+1):
  - ABSENT: s_sens=1 -> ARRIVING, cnt<=1.
  - ARRIVING: s_sens=0 -> ABSENT, cnt<=0. s_sens=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESENT, and a one-cycle arrival event is raised. Otherwise cnt++.
  - PRESENT: s_sens=0 -> LEAVING, cnt<=1.
  - LEAVING: s_sens=1 -> PRESENT, with no new arrival. s_sens=0 and cnt==DEBOUNCE_CYCLES-1 -> ABSENT. Otherwise cnt++.
  - Net latency: car rises at edge k+1+DEBOUNCE_CYCLES after sensor_raw is first sampled high at edge k.
- car_count, evaluated per edge in priority order:
  - green=1 -> 0. A simultaneous arrival is discarded, because that car passes on green.
  - Otherwise, arrival and count < 2^CNT_W-1 -> count+1.
  - Otherwise, arrival at max -> hold (saturate, no wrap).
  - car = (car_count != 0), decoded from the register with no added latency.
- Emergency FSM, with etmr as the qualify/active timer (width clog2(EMERG_MAX)+1):
  - E_IDLE: s_emerg=1 -> E_QUAL, etmr<=1. If EMERG_QUAL==1, go straight to E_ACTIVE instead.
  - E_QUAL: s_emerg=0 -> E_IDLE. etmr==EMERG_QUAL-1 -> E_ACTIVE, etmr<=0. Otherwise etmr++.
  - E_ACTIVE (emergency=1): s_emerg=0 -> E_IDLE. etmr==EMERG_MAX-1 -> E_LOCKOUT. Otherwise etmr++.
    - emergency is therefore high for at most EMERG_MAX cycles per assertion.
  - E_LOCKOUT (emergency=0, emerg_fault=1): s_emerg=0 -> E_IDLE. Otherwise hold.
  - Net latency: emergency rises at edge k+1+EMERG_QUAL. It falls at edge k+2 after emerg_raw is first sampled low at edge k.
- The car and emergency paths are fully independent. green has no effect on the emergency FSM.
- Reset mid-operation: partial qualification is lost. A new arrival requires a full DEBOUNCE_CYCLES qualification after reset release.

Test Plan:
Defaults for all scenarios: DEBOUNCE_CYCLES=4, EMERG_QUAL=2, EMERG_MAX=20, CNT_W=4, green=0 unless stated; edge 0 is the first edge to sample the stimulus.
1. Clean arrival: sensor_raw=1 for 12 cycles -> car=1 and car_count=1 from edge 5. They stay there after sensor_raw falls (no departure decrement).
2. Glitch rejection: sensor_raw=1 for 3 cycles, then 0 -> car=0 and car_count=0 throughout. Bouncing 1,0,1 during PRESENT -> no second arrival.
3. Queue and serve: three cars, each sensor high 8 / low 8, green=0 -> car_count=3. Then green=1 for one cycle -> car_count=0 and car=0 on that edge. An arrival qualifying on a green=1 edge -> count stays 0. 20 cars -> car_count saturates at 15.
4. Emergency: emerg_raw=1 for 8 cycles -> emergency=1 from edge 3, 0 from edge 10, emerg_fault=0.
5. Stuck emergency: emerg_raw=1 for 40 cycles -> emergency high on edges 3..22 only. emerg_fault=1 from edge 23, clearing 2 edges after emerg_raw is first sampled low.
6. Reset mid-operation: assert reset during ARRIVING and during E_ACTIVE -> all outputs 0 immediately and asynchronously. Sensor still high after release -> car rises DEBOUNCE_CYCLES+1 edges after the first post-reset edge.
